// File: rtl/mem_stage_ws_pkg.sv
// Shared definitions for the wait-state memory stage: opcode encodings,
// datapath widths, the default MMIO window base, the stage FSM state type
// and opcode classification helpers.
package mem_stage_ws_pkg;

  localparam int unsigned OPCODE_WIDTH      = 5;
  localparam int unsigned PC_WIDTH          = 16;
  localparam int unsigned MMIO_BASE_DEFAULT = 1020;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_AND   = 5'd2,
    OP_NOT   = 5'd3,
    OP_MOV   = 5'd4,
    OP_LDW   = 5'd5,
    OP_STW   = 5'd6,
    OP_BRN   = 5'd7,
    OP_BRZ   = 5'd8,
    OP_BRP   = 5'd9,
    OP_BRNZP = 5'd10,
    OP_JMP   = 5'd11,
    OP_JSR   = 5'd12,
    OP_JSRR  = 5'd13
  } opcode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Opcodes that redirect fetch.
  function automatic logic is_branch_op(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_BRN, OP_BRZ, OP_BRP, OP_BRNZP, OP_JMP, OP_JSR, OP_JSRR: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

  // Opcodes that update O_DestRegIdx (register-writing instructions).
  function automatic logic writes_reg_op(input logic [OPCODE_WIDTH-1:0] op);
    case (op)
      OP_ADD, OP_AND, OP_NOT, OP_MOV, OP_JSR, OP_JSRR, OP_LDW: return 1'b1;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ws_dmem.sv
// dmem_sp: single-port data RAM, DATA_W x 2**ADDR_W.
// Ports: clk_i (writes on the falling edge, matching the stage),
//        we_i, addr_i, wdata_i; rdata_o is an asynchronous read of addr_i.
// Contents are not reset.
module dmem_sp #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  always_ff @(negedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_ws.sv
// mem_stage_ws: pipeline memory stage with a wait-stated data RAM and a
// small bank of memory-mapped output registers. All state changes on the
// falling edge of I_CLOCK; I_RESET_N is asynchronous, active low.
// Inputs : I_LOCK (run enable / flush), I_Valid, I_Opcode, I_ALUOut
//          (result or address), I_DestRegIdx, I_DestValue (store data or
//          branch target).
// Outputs: O_MemStall (combinational hold request), registered writeback
//          bundle O_Valid/O_Opcode/O_ALUOut/O_MemOut/O_DestRegIdx, fetch
//          redirect O_BranchPC/O_BranchAddrSelect, and O_MMIO (register 0
//          in the LSBs).
// O_ALUOut and O_Opcode follow every consumed instruction; O_MemOut only
// changes on LDW, O_DestRegIdx only on register-writing ops, O_BranchPC
// only on branches.
module mem_stage_ws
  import mem_stage_ws_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned N_MMIO      = 4,
  parameter int unsigned MMIO_BASE   = MMIO_BASE_DEFAULT
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET_N,
  input  logic                     I_LOCK,
  input  logic                     I_Valid,
  input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
  input  logic [DATA_W-1:0]        I_ALUOut,
  input  logic [3:0]               I_DestRegIdx,
  input  logic [DATA_W-1:0]        I_DestValue,
  output logic                     O_MemStall,
  output logic                     O_Valid,
  output logic [OPCODE_WIDTH-1:0]  O_Opcode,
  output logic [DATA_W-1:0]        O_ALUOut,
  output logic [DATA_W-1:0]        O_MemOut,
  output logic [3:0]               O_DestRegIdx,
  output logic [PC_WIDTH-1:0]      O_BranchPC,
  output logic                     O_BranchAddrSelect,
  output logic [N_MMIO*DATA_W-1:0] O_MMIO
);

  localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int unsigned IDX_W = (N_MMIO > 1) ? $clog2(N_MMIO) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_STATES);
  localparam logic [DATA_W-1:0] BASE     = DATA_W'(MMIO_BASE);
  localparam logic [DATA_W-1:0] LIMIT    = DATA_W'(MMIO_BASE + N_MMIO);

  mem_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [DATA_W-1:0]       addr_q, wdata_q;
  logic [3:0]              dest_q;
  logic [DATA_W-1:0]       mmio_q [N_MMIO];

  logic [OPCODE_WIDTH-1:0] eff_op;
  logic [DATA_W-1:0]       eff_addr, eff_wdata, ram_rdata, ld_data;
  logic [3:0]              eff_dest;
  logic [IDX_W-1:0]        mmio_idx;
  logic                    is_ld, is_st, is_ram, is_mmio, stall, consume, ram_we;

  always_comb begin
    // While waiting, the instruction captured at acceptance is the one
    // being executed; the live inputs are ignored.
    if (state_q == ST_WAIT) begin
      eff_op    = op_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
      eff_dest  = dest_q;
    end else begin
      eff_op    = I_Opcode;
      eff_addr  = I_ALUOut;
      eff_wdata = I_DestValue;
      eff_dest  = I_DestRegIdx;
    end

    is_ld    = (eff_op == OP_LDW);
    is_st    = (eff_op == OP_STW);
    is_ram   = (is_ld || is_st) && (eff_addr < BASE);
    is_mmio  = (is_ld || is_st) && (eff_addr >= BASE) && (eff_addr < LIMIT);
    mmio_idx = IDX_W'(eff_addr - BASE);

    // The accepting IDLE edge of a RAM access is itself a stall edge.
    stall = 1'b0;
    if (I_LOCK) begin
      if (state_q == ST_WAIT) stall = (cnt_q != CNT_LAST);
      else                    stall = I_Valid && is_ram && (WAIT_STATES > 0);
    end

    consume = I_LOCK && !stall && ((state_q == ST_WAIT) || I_Valid);
    ram_we  = consume && is_st && is_ram;

    ld_data = '0;
    if (is_ram)       ld_data = ram_rdata;
    else if (is_mmio) ld_data = mmio_q[mmio_idx];

    state_d = state_q;
    cnt_d   = cnt_q;
    if (!I_LOCK) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_WAIT) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (stall) begin
      state_d = ST_WAIT;
      cnt_d   = CNT_W'(1);
    end
  end

  assign O_MemStall = stall;

  always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q            <= ST_IDLE;
      cnt_q              <= '0;
      op_q               <= '0;
      addr_q             <= '0;
      wdata_q            <= '0;
      dest_q             <= '0;
      O_Valid            <= 1'b0;
      O_Opcode           <= '0;
      O_ALUOut           <= '0;
      O_MemOut           <= '0;
      O_DestRegIdx       <= '0;
      O_BranchPC         <= '0;
      O_BranchAddrSelect <= 1'b0;
      for (int unsigned i = 0; i < N_MMIO; i++) mmio_q[i] <= '0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      O_Valid            <= consume;
      O_BranchAddrSelect <= consume && is_branch_op(eff_op);
      if ((state_q == ST_IDLE) && stall) begin
        op_q    <= I_Opcode;
        addr_q  <= I_ALUOut;
        wdata_q <= I_DestValue;
        dest_q  <= I_DestRegIdx;
      end
      if (consume) begin
        O_Opcode <= eff_op;
        O_ALUOut <= eff_addr;
        if (is_ld)                  O_MemOut     <= ld_data;
        if (writes_reg_op(eff_op))  O_DestRegIdx <= eff_dest;
        if (is_branch_op(eff_op))   O_BranchPC   <= I_DestValue[PC_WIDTH-1:0];
        if (is_st && is_mmio)       mmio_q[mmio_idx] <= eff_wdata;
      end
    end
  end

  for (genvar g = 0; g < N_MMIO; g++) begin : g_mmio_out
    assign O_MMIO[g*DATA_W +: DATA_W] = mmio_q[g];
  end

  dmem_sp #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dmem (
    .clk_i  (I_CLOCK),
    .we_i   (ram_we),
    .addr_i (eff_addr[ADDR_W-1:0]),
    .wdata_i(eff_wdata),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_mem_stage_ws.sv
module tb_mem_stage_ws;
  import mem_stage_ws_pkg::*;

  localparam int unsigned DW   = 16;
  localparam int unsigned WS   = 2;
  localparam int unsigned NM   = 4;
  localparam int unsigned BASE = 1020;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default wait states
  logic                    lock, valid, stall, o_valid, o_bsel;
  logic [OPCODE_WIDTH-1:0] opc, o_op;
  logic [DW-1:0]           alu, dval, o_alu, o_mem;
  logic [3:0]              dest, o_dest;
  logic [PC_WIDTH-1:0]     o_pc;
  logic [NM*DW-1:0]        o_mmio;

  // Instance Z: zero wait states
  logic                    z_lock, z_valid, z_stall, z_o_valid, z_o_bsel;
  logic [OPCODE_WIDTH-1:0] z_opc, z_o_op;
  logic [DW-1:0]           z_alu, z_dval, z_o_alu, z_o_mem;
  logic [3:0]              z_dest, z_o_dest;
  logic [PC_WIDTH-1:0]     z_o_pc;
  logic [NM*DW-1:0]        z_o_mmio;

  mem_stage_ws #(.WAIT_STATES(WS)) dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock), .I_Valid(valid),
    .I_Opcode(opc), .I_ALUOut(alu), .I_DestRegIdx(dest), .I_DestValue(dval),
    .O_MemStall(stall), .O_Valid(o_valid), .O_Opcode(o_op), .O_ALUOut(o_alu),
    .O_MemOut(o_mem), .O_DestRegIdx(o_dest), .O_BranchPC(o_pc),
    .O_BranchAddrSelect(o_bsel), .O_MMIO(o_mmio)
  );

  mem_stage_ws #(.WAIT_STATES(0)) dut_z (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(z_lock), .I_Valid(z_valid),
    .I_Opcode(z_opc), .I_ALUOut(z_alu), .I_DestRegIdx(z_dest), .I_DestValue(z_dval),
    .O_MemStall(z_stall), .O_Valid(z_o_valid), .O_Opcode(z_o_op), .O_ALUOut(z_o_alu),
    .O_MemOut(z_o_mem), .O_DestRegIdx(z_o_dest), .O_BranchPC(z_o_pc),
    .O_BranchAddrSelect(z_o_bsel), .O_MMIO(z_o_mmio)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: architectural state only
  logic [DW-1:0]       ram_m [int unsigned];
  logic [DW-1:0]       mmio_m [NM];
  logic [OPCODE_WIDTH-1:0] exp_op;
  logic [DW-1:0]       exp_alu, exp_mem;
  logic [3:0]          exp_dest;
  logic [PC_WIDTH-1:0] exp_pc;
  bit                  mem_known;

  function automatic logic [NM*DW-1:0] mmio_pack();
    logic [NM*DW-1:0] p;
    for (int i = 0; i < NM; i++) p[i*DW +: DW] = mmio_m[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NM; i++) mmio_m[i] = '0;
    exp_op = '0; exp_alu = '0; exp_mem = '0; exp_dest = '0; exp_pc = '0;
    mem_known = 1'b1;
  endtask

  task automatic edge_wait();
    @(negedge clk);
    @(posedge clk);
  endtask

  // Present one instruction and hold it until consumed; optionally drop
  // I_LOCK one edge into a RAM wait to flush it.
  task automatic issue(input logic [OPCODE_WIDTH-1:0] op, input int unsigned addr,
                       input logic [3:0] d, input logic [DW-1:0] v, input bit abort);
    bit mem, in_ram, in_mmio, brn, wr;
    int unsigned stalls, exp_st;
    logic s;
    mem     = (op == OP_LDW) || (op == OP_STW);
    in_ram  = mem && (addr < BASE);
    in_mmio = mem && (addr >= BASE) && (addr < BASE + NM);
    brn     = (op inside {OP_BRN, OP_BRZ, OP_BRP, OP_BRNZP, OP_JMP, OP_JSR, OP_JSRR});
    wr      = (op inside {OP_ADD, OP_AND, OP_NOT, OP_MOV, OP_JSR, OP_JSRR, OP_LDW});
    exp_st  = in_ram ? WS : 0;
    lock = 1'b1; valid = 1'b1; opc = op; alu = DW'(addr); dest = d; dval = v;

    if (abort && in_ram) begin
      #1 check("abort_accept_stall", stall, 1'b1);
      edge_wait();
      check("abort_wait_valid", o_valid, 1'b0);
      lock = 1'b0;
      #1 check("abort_unlocked_stall", stall, 1'b0);
      edge_wait();
      check("abort_flush_valid", o_valid, 1'b0);
      check("abort_flush_bsel", o_bsel, 1'b0);
      lock = 1'b1; valid = 1'b0;
      #1 check("abort_idle_stall", stall, 1'b0);
      edge_wait();
      check("abort_bubble_valid", o_valid, 1'b0);
      check("abort_mmio", o_mmio, mmio_pack());
      return;
    end

    stalls = 0;
    forever begin
      #1 s = stall;
      edge_wait();
      if (!s) break;
      stalls++;
      check("valid_on_stall", o_valid, 1'b0);
      if (stalls > WS + 10) break;
    end
    check("stall_edges", stalls, exp_st);

    exp_op  = op;
    exp_alu = DW'(addr);
    if (op == OP_LDW) begin
      if (in_ram) begin
        mem_known = ram_m.exists(addr);
        if (mem_known) exp_mem = ram_m[addr];
      end else if (in_mmio) begin
        exp_mem = mmio_m[addr - BASE]; mem_known = 1'b1;
      end else begin
        exp_mem = '0; mem_known = 1'b1;
      end
    end
    if (op == OP_STW) begin
      if (in_ram)       ram_m[addr] = v;
      else if (in_mmio) mmio_m[addr - BASE] = v;
    end
    if (wr)  exp_dest = d;
    if (brn) exp_pc = v[PC_WIDTH-1:0];

    check("valid", o_valid, 1'b1);
    check("opcode", o_op, exp_op);
    check("aluout", o_alu, exp_alu);
    if (mem_known) check("memout", o_mem, exp_mem);
    check("destidx", o_dest, exp_dest);
    check("bsel", o_bsel, brn);
    check("branchpc", o_pc, exp_pc);
    check("mmio", o_mmio, mmio_pack());
    valid = 1'b0;
  endtask

  task automatic bubble(input logic [OPCODE_WIDTH-1:0] op);
    lock = 1'b1; valid = 1'b0; opc = op;
    #1 check("bubble_stall", stall, 1'b0);
    edge_wait();
    check("bubble_valid", o_valid, 1'b0);
    check("bubble_bsel", o_bsel, 1'b0);
  endtask

  task automatic locked_out(input logic [OPCODE_WIDTH-1:0] op, input int unsigned addr,
                            input logic [DW-1:0] v);
    lock = 1'b0; valid = 1'b1; opc = op; alu = DW'(addr); dval = v;
    #1 check("unlocked_stall", stall, 1'b0);
    edge_wait();
    check("unlocked_valid", o_valid, 1'b0);
    check("unlocked_bsel", o_bsel, 1'b0);
    check("unlocked_mmio", o_mmio, mmio_pack());
    lock = 1'b1; valid = 1'b0;
  endtask

  task automatic z_step(input logic [OPCODE_WIDTH-1:0] op, input int unsigned addr,
                        input logic [3:0] d, input logic [DW-1:0] v);
    z_lock = 1'b1; z_valid = 1'b1; z_opc = op; z_alu = DW'(addr); z_dest = d; z_dval = v;
    #1 check("z_no_stall", z_stall, 1'b0);
    @(negedge clk);
    @(posedge clk);
    check("z_valid", z_o_valid, 1'b1);
  endtask

  logic [OPCODE_WIDTH-1:0] ops [14];
  int unsigned ram_list [16];
  int unsigned r, c, a;
  logic [OPCODE_WIDTH-1:0] rop;

  initial begin
    ops = '{OP_NOP, OP_ADD, OP_AND, OP_NOT, OP_MOV, OP_LDW, OP_STW, OP_LDW, OP_STW,
            OP_BRZ, OP_BRN, OP_JMP, OP_JSR, OP_JSRR};
    for (int i = 0; i < 15; i++) ram_list[i] = i * 63;
    ram_list[15] = BASE - 1;

    rst_n = 1'b0; lock = 1'b0; valid = 1'b0; opc = '0; alu = '0; dest = '0; dval = '0;
    z_lock = 1'b0; z_valid = 1'b0; z_opc = '0; z_alu = '0; z_dest = '0; z_dval = '0;
    model_reset();
    #23;
    check("rst_valid", o_valid, 1'b0);
    check("rst_opcode", o_op, '0);
    check("rst_aluout", o_alu, '0);
    check("rst_memout", o_mem, '0);
    check("rst_dest", o_dest, '0);
    check("rst_pc", o_pc, '0);
    check("rst_bsel", o_bsel, 1'b0);
    check("rst_mmio", o_mmio, '0);
    check("rst_stall", stall, 1'b0);
    @(posedge clk);
    rst_n = 1'b1;
    edge_wait();

    // Wait-stated RAM load / store
    issue(OP_STW, 5, 4'd0, 16'h1234, 1'b0);
    issue(OP_LDW, 5, 4'd3, 16'h0000, 1'b0);
    // MMIO store, branch, out-of-range load
    issue(OP_STW, 1020, 4'd0, 16'hBEEF, 1'b0);
    check("mmio0_beef", o_mmio[15:0], 16'hBEEF);
    issue(OP_BRZ, 0, 4'd0, 16'h0040, 1'b0);
    bubble(OP_BRZ);
    issue(OP_LDW, 1030, 4'd6, 16'h0000, 1'b0);
    // Window boundaries
    issue(OP_STW, BASE - 1, 4'd0, 16'h0BAD, 1'b0);
    issue(OP_LDW, BASE - 1, 4'd1, 16'h0000, 1'b0);
    issue(OP_STW, BASE + NM - 1, 4'd0, 16'hC0DE, 1'b0);
    issue(OP_LDW, BASE + NM - 1, 4'd2, 16'h0000, 1'b0);
    issue(OP_STW, BASE + NM, 4'd0, 16'hDEAD, 1'b0);
    issue(OP_LDW, BASE + NM, 4'd4, 16'h0000, 1'b0);
    issue(OP_STW, 7, 4'd0, 16'h7777, 1'b0);

    for (int i = 0; i < 16; i++) issue(OP_STW, ram_list[i], 4'd0, DW'($urandom), 1'b0);

    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 99);
      rop = ops[$urandom_range(0, 13)];
      c   = $urandom_range(0, 9);
      if (rop == OP_LDW || rop == OP_STW) begin
        if (c < 5)      a = ram_list[$urandom_range(0, 15)];
        else if (c < 8) a = BASE + $urandom_range(0, NM - 1);
        else if (c < 9) a = BASE + NM + $urandom_range(0, 500);
        else            a = 65535;
      end else begin
        a = $urandom_range(0, 65535);
      end
      if (r < 6)       bubble(rop);
      else if (r < 10) locked_out(c < 5 ? OP_STW : rop, BASE + $urandom_range(0, NM - 1), DW'($urandom));
      else             issue(rop, a, 4'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 7) == 0);
    end

    // Reset one edge into a RAM store wait
    lock = 1'b1; valid = 1'b1; opc = OP_STW; alu = 16'd7; dval = 16'hAAAA; dest = '0;
    #1 check("rstwait_accept_stall", stall, 1'b1);
    edge_wait();
    #1 rst_n = 1'b0;
    #1;
    check("rstwait_valid", o_valid, 1'b0);
    check("rstwait_opcode", o_op, '0);
    check("rstwait_aluout", o_alu, '0);
    check("rstwait_memout", o_mem, '0);
    check("rstwait_dest", o_dest, '0);
    check("rstwait_pc", o_pc, '0);
    check("rstwait_bsel", o_bsel, 1'b0);
    check("rstwait_mmio", o_mmio, '0);
    valid = 1'b0;
    #1 check("rstwait_idle_stall", stall, 1'b0);
    @(negedge clk);
    @(posedge clk);
    rst_n = 1'b1;
    model_reset();
    edge_wait();
    issue(OP_LDW, 7, 4'd5, 16'h0000, 1'b0);

    // Zero-wait-state instance: back-to-back LDW / ADD / STW
    z_step(OP_STW, 3, 4'd0, 16'h5A5A);
    z_step(OP_LDW, 3, 4'd8, 16'h0000);
    check("z_ldw_memout", z_o_mem, 16'h5A5A);
    check("z_ldw_dest", z_o_dest, 4'd8);
    z_step(OP_ADD, 16'h1357, 4'd9, 16'h0000);
    check("z_add_alu", z_o_alu, 16'h1357);
    check("z_add_dest", z_o_dest, 4'd9);
    z_step(OP_STW, 3, 4'd2, 16'hC3C3);
    check("z_stw_dest_hold", z_o_dest, 4'd9);
    z_step(OP_LDW, 3, 4'd1, 16'h0000);
    check("z_ldw2_memout", z_o_mem, 16'hC3C3);
    z_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    check("z_idle_valid", z_o_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
